// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU drive/return bus between the sequencer
// (master side) and the instruction source plus ALU (slave side).
interface alu_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [3:0]        alu_flags;
  logic              flag_wr;
  logic [3:0]        flag_wdata;

  modport master (
    input  instr_valid, instr, alu_out, alu_flags,
    output instr_ready, alu_in1, alu_in2, alu_op, flag_wr, flag_wdata
  );

  modport slave (
    output instr_valid, instr, alu_out, alu_flags,
    input  instr_ready, alu_in1, alu_in2, alu_op, flag_wr, flag_wdata
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-phase ALU control sequencer: accepts one instruction in IDLE, issues
// register operands to the external ALU, captures its result and flags,
// then writes back and pulses done. Owns an 8-entry register file.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sequencer_if.master    bus,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [3:0]         result_flags,
  input  logic [2:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [3:0] OP_SEC = 4'hA;
  localparam logic [3:0] OP_CLC = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;
  localparam logic [3:0] OP_NOP = 4'hD;
  localparam logic [3:0] OP_FLR = 4'hE;

  state_t            state_r;
  state_t            state_nx_s;
  logic              accept_s;
  logic [15:0]       instr_r;
  logic [DATA_W-1:0] cap_out_r;
  logic [3:0]        cap_flags_r;
  logic [DATA_W-1:0] regs_r [NREGS];

  logic [3:0] in_op_s;
  logic [2:0] in_rs_s;
  logic [2:0] in_rt_s;
  logic [3:0] op_s;
  logic [2:0] rd_s;

  assign in_op_s = bus.instr[15:12];
  assign in_rs_s = bus.instr[8:6];
  assign in_rt_s = bus.instr[5:3];
  assign op_s    = instr_r[15:12];
  assign rd_s    = instr_r[11:9];

  assign dbg_data = regs_r[dbg_addr];

  // Sequencer-internal ops (LDI, NOP, FLR) present opcode zero to the ALU.
  function automatic logic [3:0] map_op(input logic [3:0] op);
    case (op)
      OP_LDI, OP_NOP, OP_FLR: map_op = 4'h0;
      default:                map_op = op;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic; only IDLE waits on the handshake.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.instr_valid) begin
          state_nx_s = ISSUE;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE:   state_nx_s = EXEC;
      EXEC:    state_nx_s = WB;
      WB:      state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Registered bus outputs: operands, opcode and flag strobe are loaded at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r         <= 16'h0000;
      bus.instr_ready <= 1'b1;
      bus.alu_in1     <= {DATA_W{1'b0}};
      bus.alu_in2     <= {DATA_W{1'b0}};
      bus.alu_op      <= 4'h0;
      bus.flag_wr     <= 1'b0;
      bus.flag_wdata  <= 4'h0;
      done            <= 1'b0;
      cap_out_r       <= {DATA_W{1'b0}};
      cap_flags_r     <= 4'h0;
    end else begin
      bus.instr_ready <= (state_nx_s == IDLE);
      done            <= (state_nx_s == WB);
      if (accept_s) begin
        instr_r     <= bus.instr;
        bus.alu_in1 <= regs_r[in_rs_s];
        bus.alu_in2 <= regs_r[in_rt_s];
        bus.alu_op  <= map_op(in_op_s);
        bus.flag_wr <= (in_op_s == OP_FLR);
        if (in_op_s == OP_FLR) bus.flag_wdata <= regs_r[in_rs_s][3:0];
      end
      if (state_r == ISSUE) bus.flag_wr <= 1'b0;
      if (state_r == EXEC) begin
        bus.alu_op  <= 4'h0;
        cap_out_r   <= bus.alu_out;
        cap_flags_r <= bus.alu_flags;
      end
    end
  end

  // Writeback into the register file and result registers at the edge leaving WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {DATA_W{1'b0}};
      result       <= {DATA_W{1'b0}};
      result_flags <= 4'h0;
    end else if (state_r == WB) begin
      case (op_s)
        OP_SEC, OP_CLC: result_flags <= cap_flags_r;
        OP_LDI: begin
          regs_r[rd_s] <= {{(DATA_W-9){1'b0}}, instr_r[8:0]};
          result       <= {{(DATA_W-9){1'b0}}, instr_r[8:0]};
        end
        OP_NOP: ;
        OP_FLR: result_flags <= bus.flag_wdata;
        default: begin
          regs_r[rd_s] <= cap_out_r;
          result       <= cap_out_r;
          result_flags <= cap_flags_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU attached.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        done;
  logic [15:0] result;
  logic [3:0]  result_flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int fw_cnt = 0;

  alu_sequencer_if #(.DATA_W(16)) bus ();

  alu_sequencer #(.DATA_W(16), .NREGS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .done         (done),
    .result       (result),
    .result_flags (result_flags),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags[V,C,N,Z], out}.
  function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic c, v;
    s = 17'h0; r = 16'h0; c = 1'b0; v = 1'b0;
    case (op)
      4'h3: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h4: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h9: r = ~a;
      4'hA: begin r = 16'h1234; c = 1'b1; end
      4'hB: r = 16'h1234;
      default: r = a;
    endcase
    alu_model = {v, c, r[15], (r == 16'h0), r};
  endfunction

  assign {bus.alu_flags, bus.alu_out} = alu_model(bus.alu_op, bus.alu_in1, bus.alu_in2);

  // Count done pulses and flag-write cycles as seen at the ALU's sampling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.flag_wr) fw_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    enc = {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    ldi = {4'hC, rd, imm};
  endfunction

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check_val(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Issue one instruction and step through its four phases, checking the done timing.
  task automatic run_instr(input string tag, input logic [15:0] ins,
                           output logic [3:0] op_is, output logic [3:0] op_ex,
                           output logic fw_is, output logic fw_ex, output logic [3:0] fwd,
                           output logic [15:0] a1, output logic [15:0] a2);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val({tag, "_ready"}, {31'h0, bus.instr_ready}, 32'h1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = ~ins;
    @(negedge clk);
    op_is = bus.alu_op; fw_is = bus.flag_wr; fwd = bus.flag_wdata;
    a1 = bus.alu_in1; a2 = bus.alu_in2;
    check_val({tag, "_issue_rdy"}, {31'h0, bus.instr_ready}, 32'h0);
    check_val({tag, "_issue_done"}, {31'h0, done}, 32'h0);
    @(negedge clk);
    op_ex = bus.alu_op; fw_ex = bus.flag_wr;
    check_val({tag, "_exec_done"}, {31'h0, done}, 32'h0);
    @(negedge clk);
    check_val({tag, "_wb_done"}, {31'h0, done}, 32'h1);
    @(negedge clk);
    check_val({tag, "_idle_done"}, {31'h0, done}, 32'h0);
    check_val({tag, "_idle_rdy"}, {31'h0, bus.instr_ready}, 32'h1);
  endtask

  logic [3:0]  oi, oe, fwd;
  logic        fi, fe;
  logic [15:0] a1, a2;
  int          d0, f0;

  initial begin
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    dbg_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready", {31'h0, bus.instr_ready}, 32'h1);
    check_val("rst_done", {31'h0, done}, 32'h0);
    check_val("rst_flag_wr", {31'h0, bus.flag_wr}, 32'h0);
    check_val("rst_alu_op", {28'h0, bus.alu_op}, 32'h0);
    check_val("rst_result", {16'h0, result}, 32'h0);
    check_val("rst_rflags", {28'h0, result_flags}, 32'h0);
    chk_reg("rst_r1", 3'd1, 16'h0000);

    run_instr("ldi_r1", ldi(3'd1, 9'd5), oi, oe, fi, fe, fwd, a1, a2);
    check_val("ldi_r1_op", {28'h0, oi}, 32'h0);
    chk_reg("ldi_r1_val", 3'd1, 16'h0005);
    run_instr("ldi_r2", ldi(3'd2, 9'd3), oi, oe, fi, fe, fwd, a1, a2);
    chk_reg("ldi_r2_val", 3'd2, 16'h0003);
    check_val("ldi_r2_result", {16'h0, result}, 32'h3);

    run_instr("add_r3", enc(4'h3, 3'd3, 3'd1, 3'd2), oi, oe, fi, fe, fwd, a1, a2);
    check_val("add_r3_op_issue", {28'h0, oi}, 32'h3);
    check_val("add_r3_op_exec", {28'h0, oe}, 32'h3);
    check_val("add_r3_in1", {16'h0, a1}, 32'h5);
    check_val("add_r3_in2", {16'h0, a2}, 32'h3);
    check_val("add_r3_fw", {31'h0, fi}, 32'h0);
    chk_reg("add_r3_val", 3'd3, 16'h0008);
    check_val("add_r3_rflags", {28'h0, result_flags}, 32'h0);
    check_val("add_r3_result", {16'h0, result}, 32'h8);

    run_instr("ldi_r4", ldi(3'd4, 9'h1FF), oi, oe, fi, fe, fwd, a1, a2);
    chk_reg("ldi_r4_val", 3'd4, 16'h01FF);
    run_instr("sub_r5", enc(4'h4, 3'd5, 3'd1, 3'd1), oi, oe, fi, fe, fwd, a1, a2);
    check_val("sub_r5_op", {28'h0, oi}, 32'h4);
    chk_reg("sub_r5_val", 3'd5, 16'h0000);
    check_val("sub_r5_rflags", {28'h0, result_flags}, 32'h1);

    run_instr("not_r6", enc(4'h9, 3'd6, 3'd0, 3'd0), oi, oe, fi, fe, fwd, a1, a2);
    chk_reg("not_r6_val", 3'd6, 16'hFFFF);
    check_val("not_r6_rflags", {28'h0, result_flags}, 32'h2);
    run_instr("add_r7", enc(4'h3, 3'd7, 3'd6, 3'd1), oi, oe, fi, fe, fwd, a1, a2);
    chk_reg("add_r7_val", 3'd7, 16'h0004);
    check_val("add_r7_rflags", {28'h0, result_flags}, 32'h4);

    run_instr("clc", enc(4'hB, 3'd7, 3'd0, 3'd0), oi, oe, fi, fe, fwd, a1, a2);
    check_val("clc_op", {28'h0, oi}, 32'hB);
    check_val("clc_rflags", {28'h0, result_flags}, 32'h0);
    check_val("clc_result", {16'h0, result}, 32'h4);
    chk_reg("clc_r7", 3'd7, 16'h0004);
    run_instr("sec", enc(4'hA, 3'd7, 3'd0, 3'd0), oi, oe, fi, fe, fwd, a1, a2);
    check_val("sec_rflags", {28'h0, result_flags}, 32'h4);
    chk_reg("sec_r7", 3'd7, 16'h0004);

    run_instr("ldi_r2a", ldi(3'd2, 9'h00A), oi, oe, fi, fe, fwd, a1, a2);
    chk_reg("ldi_r2a_val", 3'd2, 16'h000A);
    check_val("ldi_r2a_rflags", {28'h0, result_flags}, 32'h4);
    check_val("ldi_r2a_result", {16'h0, result}, 32'hA);

    run_instr("nop", enc(4'hD, 3'd1, 3'd2, 3'd2), oi, oe, fi, fe, fwd, a1, a2);
    check_val("nop_op", {28'h0, oi}, 32'h0);
    chk_reg("nop_r1", 3'd1, 16'h0005);
    check_val("nop_result", {16'h0, result}, 32'hA);
    check_val("nop_rflags", {28'h0, result_flags}, 32'h4);

    f0 = fw_cnt;
    run_instr("flr", enc(4'hE, 3'd0, 3'd2, 3'd0), oi, oe, fi, fe, fwd, a1, a2);
    check_val("flr_fw_issue", {31'h0, fi}, 32'h1);
    check_val("flr_fw_exec", {31'h0, fe}, 32'h0);
    check_val("flr_fw_cycles", fw_cnt - f0, 32'h1);
    check_val("flr_wdata", {28'h0, fwd}, 32'hA);
    check_val("flr_op", {28'h0, oi}, 32'h0);
    check_val("flr_rflags", {28'h0, result_flags}, 32'hA);
    check_val("flr_result", {16'h0, result}, 32'hA);
    chk_reg("flr_r0", 3'd0, 16'h0000);
    chk_reg("flr_r2", 3'd2, 16'h000A);

    run_instr("add_self", enc(4'h3, 3'd1, 3'd1, 3'd1), oi, oe, fi, fe, fwd, a1, a2);
    chk_reg("add_self_r1", 3'd1, 16'h000A);
    check_val("add_self_rflags", {28'h0, result_flags}, 32'h0);

    // Reset while an ADD is in EXEC.
    @(negedge clk);
    bus.instr = enc(4'h3, 3'd3, 3'd1, 3'd2);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_mid_exec_op", {28'h0, bus.alu_op}, 32'h3);
    d0 = done_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_mid_done_cnt", done_cnt - d0, 32'h0);
    chk_reg("rst_mid_r1", 3'd1, 16'h0000);
    chk_reg("rst_mid_r3", 3'd3, 16'h0000);
    chk_reg("rst_mid_r6", 3'd6, 16'h0000);
    check_val("rst_mid_result", {16'h0, result}, 32'h0);
    check_val("rst_mid_rflags", {28'h0, result_flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_mid_ready", {31'h0, bus.instr_ready}, 32'h1);
    check_val("rst_mid_no_done", done_cnt - d0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
